// File: rtl/piso_serializer.sv
// Parallel-in, serial-out converter with a valid/ready load handshake.
// Words can be chained back to back: the next word is accepted while the last bit of the current one is on SO.
module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] PI,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             SO,
   output logic             so_valid,
   output logic             so_first,
   output logic             busy,
   output logic             done
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [CW-1:0]    r_cnt;
   logic             r_so;
   logic             r_so_valid;
   logic             r_so_first;
   logic             r_done;

   logic             w_last;
   logic             w_ready;
   logic             w_accept;

   // The bit that goes out first for a given word, depending on bit order.
   function automatic logic head_bit(input logic [WIDTH-1:0] word);
      if (LSB_FIRST) begin
         return word[0];
      end else begin
         return word[WIDTH-1];
      end
   endfunction

   // The word with its head bit removed, so the next bit moves into head position.
   function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] word);
      if (LSB_FIRST) begin
         return word >> 1'b1;
      end else begin
         return word << 1'b1;
      end
   endfunction

   // The shift register keeps only the bits not yet on SO.
   assign w_last     = (r_state == SHIFT) && (r_cnt == LAST_IDX);
   assign w_ready    = (r_state == IDLE) || w_last;
   assign w_accept   = load_valid && w_ready;

   assign load_ready = w_ready;
   assign SO         = r_so;
   assign so_valid   = r_so_valid;
   assign so_first   = r_so_first;
   assign busy       = (r_state == SHIFT);
   assign done       = r_done;

   // Serializer FSM: word capture, bit shifting, and all registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_shreg    <= '0;
         r_cnt      <= '0;
         r_so       <= 1'b0;
         r_so_valid <= 1'b0;
         r_so_first <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state    <= SHIFT;
                  r_shreg    <= drop_head(PI);
                  r_cnt      <= '0;
                  r_so       <= head_bit(PI);
                  r_so_valid <= 1'b1;
                  r_so_first <= 1'b1;
               end else begin
                  r_state    <= IDLE;
                  r_so       <= 1'b0;
                  r_so_valid <= 1'b0;
                  r_so_first <= 1'b0;
               end
            end
            SHIFT: begin
               if (w_last) begin
                  r_done <= 1'b1;
                  r_cnt  <= '0;
                  if (w_accept) begin
                     r_state    <= SHIFT;
                     r_shreg    <= drop_head(PI);
                     r_so       <= head_bit(PI);
                     r_so_valid <= 1'b1;
                     r_so_first <= 1'b1;
                  end else begin
                     r_state    <= IDLE;
                     r_shreg    <= '0;
                     r_so       <= 1'b0;
                     r_so_valid <= 1'b0;
                     r_so_first <= 1'b0;
                  end
               end else begin
                  r_state    <= SHIFT;
                  r_cnt      <= r_cnt + CW'(1);
                  r_shreg    <= drop_head(r_shreg);
                  r_so       <= head_bit(r_shreg);
                  r_so_valid <= 1'b1;
                  r_so_first <= 1'b0;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_shreg    <= '0;
               r_cnt      <= '0;
               r_so       <= 1'b0;
               r_so_valid <= 1'b0;
               r_so_first <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have parameter LSB_FIRST, default 1: 1 sends PI[0] first, 0 sends PI[WIDTH-1] first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on rising clk.
REQ-005 SHALL have port PI, input, WIDTH bits: parallel word to serialize.
REQ-006 SHALL have port load_valid, input, 1 bit: PI holds a word to send.
REQ-007 SHALL have port load_ready, output, 1 bit: serializer accepts PI on this cycle.
REQ-008 SHALL have port SO, output, 1 bit: serial data out, registered.
REQ-009 SHALL have port so_valid, output, 1 bit: SO carries a data bit this cycle, registered.
REQ-010 SHALL have port so_first, output, 1 bit: SO carries the first bit of a word, registered.
REQ-011 SHALL have port busy, output, 1 bit: a word is being shifted out.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse in the cycle after a word's last bit.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-014 SHALL accept a word at a rising edge where load_valid=1, load_ready=1 and reset=1 (the handshake).
REQ-015 SHALL drive load_ready=1 in IDLE, and in SHIFT only while the last bit of the current word is on SO; load_ready=0 otherwise.
REQ-016 SHALL, on acceptance from IDLE, move to SHIFT and present the first bit on SO the cycle immediately after the accepting edge, with so_valid=1 and so_first=1.
REQ-017 SHALL present exactly WIDTH bits on WIDTH consecutive cycles, one bit per cycle, so_valid=1 on each of them; so_first=1 on the first only.
REQ-018 SHALL capture PI into an internal shift register at acceptance; later changes on PI SHALL NOT affect the word in flight.
REQ-019 SHALL track bit position with a counter of ceil(log2(WIDTH)) bits, counting 0..WIDTH-1 and clearing on the last bit; no wrap past WIDTH-1.
REQ-020 SHALL, after the last bit with no new acceptance, return to IDLE with SO=0, so_valid=0, so_first=0.
REQ-021 SHALL, on acceptance during the last-bit cycle (back-to-back), present the next word's first bit in the following cycle with no gap, so_valid held at 1.
REQ-022 SHALL ignore load_valid whenever load_ready=0; no word is captured or lost-and-counted.
REQ-023 SHALL assert busy=1 exactly while state is SHIFT.
REQ-024 SHALL pulse done=1 for one cycle in the cycle after every word's last bit, including back-to-back cases, where it coincides with so_first=1 of the next word.
REQ-025 SHALL drive SO=0 whenever so_valid=0.

Reset
REQ-026 SHALL, at a rising edge with reset=0, force state IDLE, shift register 0, counter 0, SO=0, so_valid=0, so_first=0, busy=0, done=0.
REQ-027 SHALL abort a word in flight on reset, emitting no further bits of it and no done pulse.
REQ-028 SHALL NOT accept a word on an edge where reset=0, regardless of load_valid.
REQ-029 SHALL drive load_ready=1 from the first cycle after reset is deasserted.

Verification
REQ-030 WIDTH=4, LSB_FIRST=1, PI=4'b1011 accepted at edge k -> SO=1,1,0,1 on cycles k+1..k+4, so_first only at k+1, done at k+5, busy low from k+5.
REQ-031 WIDTH=4, LSB_FIRST=0, PI=4'b1011 -> SO=1,0,1,1; so_valid high exactly 4 cycles.
REQ-032 Back-to-back: 4'b1011 then 4'b0110, second offered during last bit -> SO=1,1,0,1,0,1,1,0 on 8 contiguous cycles, so_first at cycles 1 and 5, done at cycles 5 and 9.
REQ-033 load_valid=1 with PI=4'b1111 during bits 1..3 of word 4'b0000 -> 4'b1111 not captured; SO stays 0,0,0,0; load_ready=0 on those cycles.
REQ-034 reset=0 during bit 2 of 4'b1011 -> next cycle SO=0, so_valid=0, busy=0, no done; a new word 4'b0101 then sends 1,0,1,0 normally.
REQ-035 PI changed from 4'b1011 to 4'b0000 one cycle after acceptance -> SO still 1,1,0,1.
